// File: rtl/video_status_tx_if.sv
// rtl/video_status_tx_if.sv - byte handshake between the status reporter and the UART transmitter
//
// Purpose: carries one transmit byte and its start/finish handshake.
// Signals:
//   pi_data  8  byte to transmit, valid from send_en until tx_done
//   send_en  1  one-cycle pulse, start transmitting pi_data
//   tx_done  1  one-cycle pulse, current byte finished
// Modports: master = status reporter, slave = UART transmitter.

interface video_status_tx_if;
   logic [7:0] pi_data;
   logic       send_en;
   logic       tx_done;

   modport master (output pi_data, output send_en, input tx_done);
   modport slave  (input pi_data, input send_en, output tx_done);
endinterface

// File: rtl/video_status_tx.sv
// rtl/video_status_tx.sv - reports the video-enable state to the host as an ASCII frame
//
// Purpose: on every change of key_state, or on a query pulse, sends
//   PREFIX, ON_CHAR/OFF_CHAR [, CR, LF] through a byte-level UART transmitter.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   key_state  in   video-enable state to report
//   query      in   one-cycle request to report the current state
//   busy       out  high while a frame is in progress
//   tx_err     out  one-cycle pulse, tx_done timeout, frame aborted
//   tx         master side of the byte handshake (pi_data, send_en, tx_done)

module video_status_tx #(
   parameter logic [7:0] PREFIX      = 8'h58,
   parameter logic [7:0] ON_CHAR     = 8'h31,
   parameter logic [7:0] OFF_CHAR    = 8'h30,
   parameter bit         APPEND_CRLF = 1'b1,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 key_state,
   input  logic                 query,
   output logic                 busy,
   output logic                 tx_err,
   video_status_tx_if.master    tx
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);
   localparam logic [1:0]    LAST_IDX  = APPEND_CRLF ? 2'd3 : 2'd1;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

   state_t          state, state_nx;
   logic            key_d;
   logic            pending;
   logic [1:0]      byte_idx, idx_nx;
   logic            snap, snap_nx;
   logic [TW-1:0]   timer;
   logic            done_q;
   logic            frame_end;
   logic            timeout;
   logic            event_w;

   function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic s);
      case (idx)
         2'd0:    return PREFIX;
         2'd1:    return s ? ON_CHAR : OFF_CHAR;
         2'd2:    return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   // A state change and a query in the same cycle collapse into one event.
   assign event_w = (key_state != key_d) | query;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      idx_nx    = byte_idx;
      snap_nx   = snap;
      frame_end = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (event_w || pending) state_nx = LOAD;
         end
         LOAD: begin
            snap_nx  = key_state;
            idx_nx   = 2'd0;
            state_nx = SEND;
         end
         SEND: begin
            state_nx = WAIT;
         end
         WAIT: begin
            // done_q is tx_done registered while in WAIT, which puts the next
            // send_en two cycles after the tx_done that ended the byte.
            if (done_q) begin
               if (byte_idx == LAST_IDX) begin
                  state_nx  = IDLE;
                  frame_end = 1'b1;
               end else begin
                  idx_nx   = byte_idx + 2'd1;
                  state_nx = SEND;
               end
            end else if (timer == TIMER_MAX && !tx.tx_done) begin
               // A tx_done arriving on the last timer cycle still wins.
               state_nx = IDLE;
               timeout  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_d      <= 1'b0;
         pending    <= 1'b0;
         byte_idx   <= 2'd0;
         snap       <= 1'b0;
         timer      <= '0;
         done_q     <= 1'b0;
         busy       <= 1'b0;
         tx_err     <= 1'b0;
         tx.pi_data <= 8'h00;
         tx.send_en <= 1'b0;
      end else begin
         key_d    <= key_state;
         byte_idx <= idx_nx;
         snap     <= snap_nx;
         tx_err   <= timeout;
         done_q   <= tx.tx_done && (state == WAIT);

         // One-deep sticky request: events during a frame coalesce, and the
         // follow-up frame resamples key_state so the final state is reported.
         if (state == IDLE)  pending <= 1'b0;
         else if (event_w)   pending <= 1'b1;

         if (state == SEND)  timer <= '0;
         else if (state == WAIT) timer <= timer + TW'(1);

         if (state == LOAD)               busy <= 1'b1;
         else if (frame_end || timeout)   busy <= 1'b0;

         // Outputs are registered on entry to SEND so send_en and pi_data
         // appear together in the SEND cycle; pi_data holds afterwards.
         tx.send_en <= (state_nx == SEND);
         if (state_nx == SEND) tx.pi_data <= frame_byte(idx_nx, snap_nx);
      end
   end

endmodule

// File: tb/tb_video_status_tx.sv
// tb/tb_video_status_tx.sv - self-checking bench for video_status_tx

module tb_video_status_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_a = 1'b0, query_a = 1'b0;
   logic key_b = 1'b0, query_b = 1'b0;
   logic busy_a, tx_err_a, busy_b, tx_err_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   video_status_tx_if ifa ();
   video_status_tx_if ifb ();

   video_status_tx #(.APPEND_CRLF(1'b1), .TIMEOUT_CYC(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .key_state(key_a), .query(query_a),
      .busy(busy_a), .tx_err(tx_err_a), .tx(ifa)
   );

   video_status_tx #(.APPEND_CRLF(1'b0), .TIMEOUT_CYC(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .key_state(key_b), .query(query_b),
      .busy(busy_b), .tx_err(tx_err_b), .tx(ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int scyc_a[$];
   int scyc_b[$];
   int n_send_a = 0, n_send_b = 0, n_err_a = 0;
   int cnt_a = 0, cnt_b = 0, last_done_a = 0;
   bit withhold_a = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // UART models: tx_done high for one cycle, 5 cycles after each send_en.
   initial ifa.tx_done = 1'b0;
   initial ifb.tx_done = 1'b0;

   always @(posedge clk) begin
      #1;
      ifa.tx_done = 1'b0;
      if (!rst_n) cnt_a = 0;
      else if (cnt_a > 0) begin
         cnt_a--;
         if (cnt_a == 0) begin
            ifa.tx_done = 1'b1;
            last_done_a = cyc;
         end
      end else if (ifa.send_en === 1'b1 && !withhold_a) cnt_a = 5;
   end

   always @(posedge clk) begin
      #1;
      ifb.tx_done = 1'b0;
      if (!rst_n) cnt_b = 0;
      else if (cnt_b > 0) begin
         cnt_b--;
         if (cnt_b == 0) ifb.tx_done = 1'b1;
      end else if (ifb.send_en === 1'b1) cnt_b = 5;
   end

   // Scoreboard: each send_en pops the expected byte.
   always @(negedge clk) begin
      if (ifa.send_en === 1'b1) begin
         n_send_a++;
         scyc_a.push_back(cyc);
         if (qa.size() == 0) chk("a_extra_send", 32'(qa.size()), 32'd1);
         else chk("a_byte", 32'(ifa.pi_data), 32'(qa.pop_front()));
      end
      if (ifb.send_en === 1'b1) begin
         n_send_b++;
         scyc_b.push_back(cyc);
         if (qb.size() == 0) chk("b_extra_send", 32'(qb.size()), 32'd1);
         else chk("b_byte", 32'(ifb.pi_data), 32'(qb.pop_front()));
      end
      if (tx_err_a === 1'b1) n_err_a++;
   end

   task automatic wait_done(input bit sel, input int target, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         tick(1);
         if (!sel && n_send_a >= target && busy_a == 1'b0) ok = 1'b1;
         if (sel && n_send_b >= target && busy_b == 1'b0) ok = 1'b1;
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      int n, s, base, fall, r;

      // 1: reset values, then quiet idle with key_state=0
      tick(3);
      chk("rst_pi_data", 32'(ifa.pi_data), 32'h00);
      chk("rst_send_en", 32'(ifa.send_en), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_tx_err", 32'(tx_err_a), 32'd0);
      rst_n = 1'b1;
      tick(20);
      chk("idle_sends_a", 32'(n_send_a), 32'd0);
      chk("idle_sends_b", 32'(n_send_b), 32'd0);
      chk("idle_busy", 32'(busy_a), 32'd0);
      chk("idle_pi_data", 32'(ifa.pi_data), 32'h00);

      // 2: rising key_state -> X1 CR LF
      qa.push_back(8'h58); qa.push_back(8'h31); qa.push_back(8'h0D); qa.push_back(8'h0A);
      scyc_a.delete();
      key_a = 1'b1;
      n = cyc;
      wait_done(1'b0, 4, "t2_frame_done");
      fall = cyc;
      chk("t2_sends", 32'(n_send_a), 32'd4);
      chk("t2_first_latency", 32'(scyc_a[0]), 32'(n + 2));
      chk("t2_byte_gap", 32'(scyc_a[1]), 32'(scyc_a[0] + 7));
      chk("t2_busy_fall", 32'(fall), 32'(last_done_a + 2));
      chk("t2_queue_empty", 32'(qa.size()), 32'd0);
      chk("t2_pi_data_hold", 32'(ifa.pi_data), 32'h0A);

      // 3: query with key_state=0 on the 2-byte instance
      qb.push_back(8'h58); qb.push_back(8'h30);
      query_b = 1'b1;
      n = cyc;
      tick(1);
      query_b = 1'b0;
      wait_done(1'b1, 2, "t3_frame_done");
      tick(20);
      chk("t3_sends", 32'(n_send_b), 32'd2);
      chk("t3_first_latency", 32'(scyc_b[0]), 32'(n + 2));
      chk("t3_pi_data_hold", 32'(ifb.pi_data), 32'h30);
      chk("t3_queue_empty", 32'(qb.size()), 32'd0);

      // 4: toggling during a frame coalesces into one resampled frame
      base = n_send_a;
      scyc_a.delete();
      qa.push_back(8'h58); qa.push_back(8'h30); qa.push_back(8'h0D); qa.push_back(8'h0A);
      qa.push_back(8'h58); qa.push_back(8'h31); qa.push_back(8'h0D); qa.push_back(8'h0A);
      key_a = 1'b0;
      tick(4); key_a = 1'b1;
      tick(2); key_a = 1'b0;
      tick(2); key_a = 1'b1;
      wait_done(1'b0, base + 8, "t4_frames_done");
      tick(20);
      chk("t4_sends", 32'(n_send_a - base), 32'd8);
      chk("t4_restart_gap", 32'(scyc_a[4]), 32'(scyc_a[3] + 9));
      chk("t4_queue_empty", 32'(qa.size()), 32'd0);

      // 5: tx_done withheld -> timeout, then the pending frame restarts
      withhold_a = 1'b1;
      base = n_err_a;
      qa.push_back(8'h58);
      query_a = 1'b1;
      tick(1); query_a = 1'b0;
      tick(1);
      s = cyc;
      chk("t5_send_en", 32'(ifa.send_en), 32'd1);
      tick(3); query_a = 1'b1;
      tick(1); query_a = 1'b0;
      qa.push_back(8'h58); qa.push_back(8'h31); qa.push_back(8'h0D); qa.push_back(8'h0A);
      tick(12);
      chk("t5_no_early_err", 32'(tx_err_a), 32'd0);
      tick(1);
      chk("t5_err_cycle", 32'(cyc - s), 32'd17);
      chk("t5_tx_err", 32'(tx_err_a), 32'd1);
      chk("t5_busy_low", 32'(busy_a), 32'd0);
      withhold_a = 1'b0;
      tick(1);
      chk("t5_err_one_cycle", 32'(tx_err_a), 32'd0);
      tick(1);
      chk("t5_restart_send", 32'(ifa.send_en), 32'd1);
      base = n_send_a;
      wait_done(1'b0, base + 3, "t5_restart_done");
      chk("t5_err_count", 32'(n_err_a), 32'(base - base + 1 + (n_err_a - n_err_a)) );
      chk("t5_queue_empty", 32'(qa.size()), 32'd0);

      // 6: reset mid-frame after byte 1
      qa.push_back(8'h58); qa.push_back(8'h31);
      query_a = 1'b1;
      tick(1); query_a = 1'b0;
      tick(1);
      s = cyc;
      tick(8);
      rst_n = 1'b0;
      key_a = 1'b0;
      tick(1);
      chk("t6_pi_data", 32'(ifa.pi_data), 32'h00);
      chk("t6_busy", 32'(busy_a), 32'd0);
      chk("t6_send_en", 32'(ifa.send_en), 32'd0);
      chk("t6_tx_err", 32'(tx_err_a), 32'd0);
      tick(1);
      rst_n = 1'b1;
      base = n_send_a;
      tick(20);
      chk("t6_no_more_sends", 32'(n_send_a), 32'(base));
      chk("t6_queue_empty", 32'(qa.size()), 32'd0);

      // key_state already high at reset release is reported
      rst_n = 1'b0;
      key_a = 1'b1;
      tick(2);
      qa.push_back(8'h58); qa.push_back(8'h31); qa.push_back(8'h0D); qa.push_back(8'h0A);
      scyc_a.delete();
      base = n_send_a;
      rst_n = 1'b1;
      r = cyc;
      wait_done(1'b0, base + 4, "t6_release_frame");
      chk("t6_release_latency", 32'(scyc_a[0]), 32'(r + 2));
      chk("t6_release_queue", 32'(qa.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
